mem_req_arbiter: RTL and testbench

Two-requester arbiter that shares one 4B memory port between the processor's instruction-fetch and data streams. It sits between the processor's imem/dmem request/response ports and a single-ported memory, choosing which request to issue each cycle. It records the grant order in an internal in-order tag FIFO so each response is routed back to the requester that issued it. The memory must return responses in request order.

---
 rtl/mem_req_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter sharing one 4B memory port between imem and dmem; an in-order tag FIFO routes each response back.
// Optional build macro MEM_REQ_ARBITER_DMEM_PRIORITY_EN selects fixed dmem priority instead of round-robin.

package mem_req_arbiter_pkg;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// Simulation-only protocol monitor for the memory response channel.
module mem_req_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic memresp_val,
  input logic fifo_empty
);

  // A response with nothing in flight means the memory side is out of sync.
  always_ff @(posedge clk) begin
    if (reset && memresp_val && fifo_empty) begin
      $error("mem_req_arbiter: memresp_val asserted with no outstanding request");
    end else begin
    end
  end

endmodule

module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  mem_req_4B_t                        imemreq_msg,
  input  logic                               imemreq_val,
  output logic                               imemreq_rdy,
  output mem_resp_4B_t                       imemresp_msg,
  output logic                               imemresp_val,
  input  logic                               imemresp_rdy,
  input  mem_req_4B_t                        dmemreq_msg,
  input  logic                               dmemreq_val,
  output logic                               dmemreq_rdy,
  output mem_resp_4B_t                       dmemresp_msg,
  output logic                               dmemresp_val,
  input  logic                               dmemresp_rdy,
  output mem_req_4B_t                        memreq_msg,
  output logic                               memreq_val,
  input  logic                               memreq_rdy,
  input  mem_resp_4B_t                       memresp_msg,
  input  logic                               memresp_val,
  output logic                               memresp_rdy,
  output logic [$clog2(p_max_outstanding):0] num_outstanding
);

  localparam int PTR_W = $clog2(p_max_outstanding);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(p_max_outstanding);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  logic             tag_r [p_max_outstanding];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic full_s;
  logic empty_s;
  logic both_pick_s;
  logic grant_val_s;
  logic grant_id_s;
  logic head_tag_s;
  logic req_fire_s;
  logic resp_fire_s;

  assign full_s     = (count_r == CNT_FULL);
  assign empty_s    = (count_r == CNT_ZERO);
  assign head_tag_s = tag_r[head_r];

`ifdef MEM_REQ_ARBITER_DMEM_PRIORITY_EN
  assign both_pick_s = 1'b1;
`else
  logic prio_r;

  assign both_pick_s = prio_r;

  // Round-robin: after each issued request the other requester is favoured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_r <= 1'b0;
    end else if (req_fire_s) begin
      prio_r <= ~grant_id_s;
    end else begin
      prio_r <= prio_r;
    end
  end
`endif

  // Pick a requester; a full FIFO blocks every grant regardless of same-cycle pops.
  always_comb begin
    grant_val_s = 1'b0;
    grant_id_s  = 1'b0;
    if (full_s) begin
      grant_val_s = 1'b0;
    end else if (imemreq_val && dmemreq_val) begin
      grant_val_s = 1'b1;
      grant_id_s  = both_pick_s;
    end else if (imemreq_val) begin
      grant_val_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (dmemreq_val) begin
      grant_val_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_val_s = 1'b0;
    end
  end

  // Request mux; outputs are forced low while reset is asserted.
  always_comb begin
    memreq_val  = 1'b0;
    memreq_msg  = imemreq_msg;
    imemreq_rdy = 1'b0;
    dmemreq_rdy = 1'b0;
    if (reset && grant_val_s) begin
      memreq_val = 1'b1;
      if (grant_id_s) begin
        memreq_msg  = dmemreq_msg;
        dmemreq_rdy = memreq_rdy;
      end else begin
        memreq_msg  = imemreq_msg;
        imemreq_rdy = memreq_rdy;
      end
    end else begin
      memreq_val = 1'b0;
    end
  end

  // Response demux steered by the oldest outstanding tag.
  always_comb begin
    imemresp_val = 1'b0;
    dmemresp_val = 1'b0;
    memresp_rdy  = 1'b0;
    if (reset && !empty_s) begin
      if (head_tag_s) begin
        dmemresp_val = memresp_val;
        memresp_rdy  = dmemresp_rdy;
      end else begin
        imemresp_val = memresp_val;
        memresp_rdy  = imemresp_rdy;
      end
    end else begin
      memresp_rdy = 1'b0;
    end
  end

  assign imemresp_msg    = memresp_msg;
  assign dmemresp_msg    = memresp_msg;
  assign req_fire_s      = memreq_val && memreq_rdy;
  assign resp_fire_s     = memresp_val && memresp_rdy;
  assign num_outstanding = count_r;

  // Grant-order tag FIFO; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      for (int i = 0; i < p_max_outstanding; i++) begin
        tag_r[i] <= 1'b0;
      end
    end else begin
      if (req_fire_s) begin
        tag_r[tail_r] <= grant_id_s;
        tail_r        <= tail_r + PTR_ONE;
      end else begin
        tail_r <= tail_r;
      end
      if (resp_fire_s) begin
        head_r <= head_r + PTR_ONE;
      end else begin
        head_r <= head_r;
      end
      case ({req_fire_s, resp_fire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifndef SYNTHESIS
  mem_req_arbiter_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .memresp_val (memresp_val),
    .fifo_empty  (empty_s)
  );
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (depth 4); expectations follow
// MEM_REQ_ARBITER_DMEM_PRIORITY_EN when that macro is defined.

module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  mem_req_4B_t  imemreq_msg, dmemreq_msg, memreq_msg;
  mem_resp_4B_t imemresp_msg, dmemresp_msg, memresp_msg;
  logic         imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
  logic         dmemreq_val, dmemreq_rdy, dmemresp_val, dmemresp_rdy;
  logic         memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [2:0]   num_outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  mem_req_arbiter #(.p_max_outstanding(4)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .num_outstanding(num_outstanding)
  );

  always #5 clk = ~clk;

  function automatic mem_req_4B_t mk_req(input logic [31:0] addr);
    mem_req_4B_t r;
    r = '0;
    r.addr = addr;
    return r;
  endfunction

  function automatic mem_resp_4B_t mk_resp(input logic [31:0] data);
    mem_resp_4B_t r;
    r = '0;
    r.data = data;
    return r;
  endfunction

  task automatic drive_idle();
    imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0;
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memreq_rdy = 1'b0;
    imemresp_rdy = 1'b0; dmemresp_rdy = 1'b0; memresp_val = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    imemreq_val = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b1; imemresp_rdy = 1'b1;
    #2;
    n_checks++; if (num_outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", num_outstanding); end
    n_checks++; if (memreq_val !== 1'b0) begin n_fail++; $display("FAIL reset_memreq_val: got %b expected 0", memreq_val); end
    n_checks++; if (imemreq_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_imemreq_rdy: got %b expected 0", imemreq_rdy); end
    n_checks++; if (memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_memresp_rdy: got %b expected 0", memresp_rdy); end
    n_checks++; if (imemresp_val !== 1'b0) begin n_fail++; $display("FAIL reset_imemresp_val: got %b expected 0", imemresp_val); end
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_imem_only();
    do_reset();
    imemreq_msg = mk_req(32'h200); imemreq_val = 1'b1; memreq_rdy = 1'b1;
    #1;
    n_checks++; if (memreq_val !== 1'b1) begin n_fail++; $display("FAIL imem_memreq_val: got %b expected 1", memreq_val); end
    n_checks++; if (memreq_msg.addr !== 32'h200) begin n_fail++; $display("FAIL imem_addr: got %h expected 00000200", memreq_msg.addr); end
    n_checks++; if (imemreq_rdy !== 1'b1) begin n_fail++; $display("FAIL imem_imemreq_rdy: got %b expected 1", imemreq_rdy); end
    n_checks++; if (dmemreq_rdy !== 1'b0) begin n_fail++; $display("FAIL imem_dmemreq_rdy: got %b expected 0", dmemreq_rdy); end
    n_checks++; if (num_outstanding !== 3'd0) begin n_fail++; $display("FAIL imem_count_before: got %0d expected 0", num_outstanding); end
    step();
    n_checks++; if (num_outstanding !== 3'd1) begin n_fail++; $display("FAIL imem_count_after: got %0d expected 1", num_outstanding); end
    @(negedge clk);
    imemreq_val = 1'b0;
    memresp_val = 1'b1; memresp_msg = mk_resp(32'h55); imemresp_rdy = 1'b1;
    #1;
    n_checks++; if (imemresp_val !== 1'b1) begin n_fail++; $display("FAIL imem_resp_val: got %b expected 1", imemresp_val); end
    n_checks++; if (dmemresp_val !== 1'b0) begin n_fail++; $display("FAIL imem_dresp_val: got %b expected 0", dmemresp_val); end
    n_checks++; if (imemresp_msg.data !== 32'h55) begin n_fail++; $display("FAIL imem_resp_data: got %h expected 00000055", imemresp_msg.data); end
    step();
    n_checks++; if (num_outstanding !== 3'd0) begin n_fail++; $display("FAIL imem_count_drain: got %0d expected 0", num_outstanding); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_round_robin();
    logic        exp_id [4];
    logic [31:0] exp_addr;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_REQ_ARBITER_DMEM_PRIORITY_EN
      exp_id[k] = 1'b1;
`else
      exp_id[k] = k[0];
`endif
    end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      imemreq_msg = mk_req(32'h100 + 32'(k)); dmemreq_msg = mk_req(32'h200 + 32'(k));
      imemreq_val = 1'b1; dmemreq_val = 1'b1; memreq_rdy = 1'b1;
      #1;
      exp_addr = exp_id[k] ? (32'h200 + 32'(k)) : (32'h100 + 32'(k));
      n_checks++; if (memreq_msg.addr !== exp_addr) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h expected %h", k, memreq_msg.addr, exp_addr); end
      n_checks++; if (dmemreq_rdy !== exp_id[k]) begin n_fail++; $display("FAIL rr_drdy[%0d]: got %b expected %b", k, dmemreq_rdy, exp_id[k]); end
      n_checks++; if (imemreq_rdy !== !exp_id[k]) begin n_fail++; $display("FAIL rr_irdy[%0d]: got %b expected %b", k, imemreq_rdy, !exp_id[k]); end
      step();
      @(negedge clk);
    end
    n_checks++; if (num_outstanding !== 3'd4) begin n_fail++; $display("FAIL rr_count_full: got %0d expected 4", num_outstanding); end
    imemreq_val = 1'b0; dmemreq_val = 1'b0;
    imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      memresp_val = 1'b1; memresp_msg = mk_resp(32'hA + 32'(k));
      #1;
      n_checks++; if (dmemresp_val !== exp_id[k]) begin n_fail++; $display("FAIL rr_dresp_val[%0d]: got %b expected %b", k, dmemresp_val, exp_id[k]); end
      n_checks++; if (imemresp_val !== !exp_id[k]) begin n_fail++; $display("FAIL rr_iresp_val[%0d]: got %b expected %b", k, imemresp_val, !exp_id[k]); end
      n_checks++; if ((exp_id[k] ? dmemresp_msg.data : imemresp_msg.data) !== 32'hA + 32'(k)) begin n_fail++; $display("FAIL rr_resp_data[%0d]: got %h expected %h", k, exp_id[k] ? dmemresp_msg.data : imemresp_msg.data, 32'hA + 32'(k)); end
      step();
      @(negedge clk);
    end
    n_checks++; if (num_outstanding !== 3'd0) begin n_fail++; $display("FAIL rr_count_drain: got %0d expected 0", num_outstanding); end
    drive_idle();
  endtask

  task automatic test_full();
    do_reset();
    memreq_rdy = 1'b1; imemreq_val = 1'b1; imemresp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imemreq_msg = mk_req(32'h300 + 32'(k));
      #1;
      n_checks++; if (imemreq_rdy !== 1'b1) begin n_fail++; $display("FAIL full_fill_rdy[%0d]: got %b expected 1", k, imemreq_rdy); end
      step();
      @(negedge clk);
    end
    n_checks++; if (num_outstanding !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", num_outstanding); end
    imemreq_msg = mk_req(32'h304);
    #1;
    n_checks++; if (memreq_val !== 1'b0) begin n_fail++; $display("FAIL full_memreq_val: got %b expected 0", memreq_val); end
    n_checks++; if (imemreq_rdy !== 1'b0) begin n_fail++; $display("FAIL full_imemreq_rdy: got %b expected 0", imemreq_rdy); end
    step();
    @(negedge clk);
    memresp_val = 1'b1; memresp_msg = mk_resp(32'h1);
    #1;
    n_checks++; if (memreq_val !== 1'b0) begin n_fail++; $display("FAIL full_pop_memreq_val: got %b expected 0", memreq_val); end
    n_checks++; if (memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL full_pop_memresp_rdy: got %b expected 1", memresp_rdy); end
    step();
    n_checks++; if (num_outstanding !== 3'd3) begin n_fail++; $display("FAIL full_after_pop: got %0d expected 3", num_outstanding); end
    @(negedge clk);
    memresp_val = 1'b0;
    #1;
    n_checks++; if (imemreq_rdy !== 1'b1) begin n_fail++; $display("FAIL full_fifth_fires: got %b expected 1", imemreq_rdy); end
    step();
    n_checks++; if (num_outstanding !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d expected 4", num_outstanding); end
    @(negedge clk);
    imemreq_val = 1'b0; memresp_val = 1'b1;
    repeat (4) step();
    n_checks++; if (num_outstanding !== 3'd0) begin n_fail++; $display("FAIL full_drain: got %0d expected 0", num_outstanding); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_resp_backpressure();
    do_reset();
    dmemreq_msg = mk_req(32'h500); dmemreq_val = 1'b1; memreq_rdy = 1'b1;
    step();
    @(negedge clk);
    dmemreq_val = 1'b0;
    memresp_val = 1'b1; memresp_msg = mk_resp(32'h9); dmemresp_rdy = 1'b0; imemresp_rdy = 1'b1;
    #1;
    n_checks++; if (memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_memresp_rdy: got %b expected 0", memresp_rdy); end
    n_checks++; if (imemresp_val !== 1'b0) begin n_fail++; $display("FAIL bp_imemresp_val: got %b expected 0", imemresp_val); end
    n_checks++; if (dmemresp_val !== 1'b1) begin n_fail++; $display("FAIL bp_dmemresp_val: got %b expected 1", dmemresp_val); end
    step();
    n_checks++; if (num_outstanding !== 3'd1) begin n_fail++; $display("FAIL bp_hold: got %0d expected 1", num_outstanding); end
    @(negedge clk);
    dmemresp_rdy = 1'b1;
    #1;
    n_checks++; if (memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy: got %b expected 1", memresp_rdy); end
    step();
    n_checks++; if (num_outstanding !== 3'd0) begin n_fail++; $display("FAIL bp_pop: got %0d expected 0", num_outstanding); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic q[$];
    logic who;
    do_reset();
    memreq_rdy = 1'b1; imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1;
    imemreq_val = 1'b1;
    step(); @(negedge clk);
    imemreq_val = 1'b0; dmemreq_val = 1'b1;
    step(); @(negedge clk);
    q.push_back(1'b0); q.push_back(1'b1);
    n_checks++; if (num_outstanding !== 3'd2) begin n_fail++; $display("FAIL b2b_prefill: got %0d expected 2", num_outstanding); end
    for (int k = 0; k < 8; k++) begin
      who = k[0];
      imemreq_val = !who; dmemreq_val = who;
      memresp_val = 1'b1; memresp_msg = mk_resp(32'h50 + 32'(k));
      #1;
      n_checks++; if (imemresp_val !== (q[0] == 1'b0)) begin n_fail++; $display("FAIL b2b_iresp[%0d]: got %b expected %b", k, imemresp_val, q[0] == 1'b0); end
      n_checks++; if (dmemresp_val !== (q[0] == 1'b1)) begin n_fail++; $display("FAIL b2b_dresp[%0d]: got %b expected %b", k, dmemresp_val, q[0] == 1'b1); end
      step();
      void'(q.pop_front());
      q.push_back(who);
      n_checks++; if (num_outstanding !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 2", k, num_outstanding); end
      @(negedge clk);
    end
    imemreq_val = 1'b0; dmemreq_val = 1'b0;
    repeat (2) step();
    n_checks++; if (num_outstanding !== 3'd0) begin n_fail++; $display("FAIL b2b_drain: got %0d expected 0", num_outstanding); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    memreq_rdy = 1'b1; imemreq_val = 1'b1;
    repeat (3) step();
    n_checks++; if (num_outstanding !== 3'd3) begin n_fail++; $display("FAIL rstmid_fill: got %0d expected 3", num_outstanding); end
    @(negedge clk);
    memresp_val = 1'b1; imemresp_rdy = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (num_outstanding !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", num_outstanding); end
    n_checks++; if (memreq_val !== 1'b0) begin n_fail++; $display("FAIL rstmid_memreq_val: got %b expected 0", memreq_val); end
    n_checks++; if (imemreq_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_imemreq_rdy: got %b expected 0", imemreq_rdy); end
    n_checks++; if (imemresp_val !== 1'b0) begin n_fail++; $display("FAIL rstmid_imemresp_val: got %b expected 0", imemresp_val); end
    n_checks++; if (memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_memresp_rdy: got %b expected 0", memresp_rdy); end
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    imemreq_msg = mk_req(32'h400); imemreq_val = 1'b1; memreq_rdy = 1'b1;
    step(); @(negedge clk);
    imemreq_val = 1'b0;
    memresp_val = 1'b1; memresp_msg = mk_resp(32'h77); imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1;
    #1;
    n_checks++; if (imemresp_val !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_iresp: got %b expected 1", imemresp_val); end
    n_checks++; if (dmemresp_val !== 1'b0) begin n_fail++; $display("FAIL rstmid_new_dresp: got %b expected 0", dmemresp_val); end
    n_checks++; if (imemresp_msg.data !== 32'h77) begin n_fail++; $display("FAIL rstmid_new_data: got %h expected 00000077", imemresp_msg.data); end
    step();
    n_checks++; if (num_outstanding !== 3'd0) begin n_fail++; $display("FAIL rstmid_new_pop: got %0d expected 0", num_outstanding); end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_imem_only();
    test_round_robin();
    test_full();
    test_resp_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
